// File: rtl/soqpsk_pkg.sv
// Shared encodings and helpers for the SOQPSK ternary receive path.
package soqpsk_pkg;

  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_NEG  = 2'b11;

  localparam int DW_DEF = 18;
  localparam int CW_DEF = 16;

  // Data bit to antipodal level: 1 -> +1, 0 -> -1.
  function automatic logic signed [1:0] bitSign(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/soqpsk_ternary_decoder_if.sv
// Discriminator-side inputs, configuration and recovered-bit outputs of the ternary decoder.
interface soqpsk_ternary_decoder_if import soqpsk_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  logic                 sampleEn;
  logic signed [DW-1:0] discIn;
  logic                 symSync;
  logic [CW-1:0]        symDivider;
  logic [3:0]           accShift;
  logic [DW-1:0]        threshold;
  logic [1:0]           ternOut;
  logic                 bitOut;
  logic                 bitValid;
  logic                 bitClk;
  logic                 signErr;
  logic [15:0]          errCount;

  modport master (
    output sampleEn, discIn, symSync, symDivider, accShift, threshold,
    input  ternOut, bitOut, bitValid, bitClk, signErr, errCount
  );

  modport slave (
    input  sampleEn, discIn, symSync, symDivider, accShift, threshold,
    output ternOut, bitOut, bitValid, bitClk, signErr, errCount
  );
endinterface

// File: rtl/soqpsk_int_dump.sv
// Per-symbol integrate-and-dump of discriminator samples with symbol-phase restart.
module soqpsk_int_dump import soqpsk_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int AW = DW + CW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sampleEn,
  input  logic signed [DW-1:0] discIn,
  input  logic                 symSync,
  input  logic [CW-1:0]        symDivider,
  output logic signed [AW-1:0] dump,
  output logic                 dumpEn
);

  logic [CW-1:0]        cnt;
  logic                 armed;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] discExt;
  logic [CW-1:0]        effCnt;

  // Until the first sample after reset, the count behaves as freshly loaded from symDivider.
  always_comb begin
    effCnt  = armed ? cnt : symDivider;
    discExt = {{(AW-DW){discIn[DW-1]}}, discIn};
    dump    = acc + discExt;
    dumpEn  = sampleEn && !symSync && (effCnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      armed <= 1'b0;
      acc   <= '0;
    end else if (symSync) begin
      cnt   <= symDivider;
      armed <= 1'b1;
      acc   <= '0;
    end else if (sampleEn) begin
      armed <= 1'b1;
      if (effCnt == '0) begin
        cnt <= symDivider;
        acc <= '0;
      end else begin
        cnt <= effCnt - CW'(1);
        acc <= dump;
      end
    end
  end

endmodule

// File: rtl/soqpsk_ternary_decoder.sv
// SOQPSK receive decoder: slices integrated discriminator output to {-1,0,+1},
// inverts the precoder and flags sign-rule violations.
module soqpsk_ternary_decoder import soqpsk_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int AW = DW + CW
) (
  input logic               clk,
  input logic               reset,
  soqpsk_ternary_decoder_if.slave bus
);

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic signed [AW-1:0] dump_p0;
  logic                 dumpEn_p0;
  logic signed [DW:0]   n_p0;
  logic signed [DW:0]   thr_p0;
  logic [1:0]           tern_p0;

  logic [1:0]           ternOut_p1;
  logic                 vld_p1;

  logic                 alphaNz;
  logic                 bitNew;
  logic signed [1:0]    prod;
  logic signed [1:0]    expSign;
  logic                 viol;
  logic [CW-1:0]        halfLoad;

  logic                 bitOut_p2;
  logic                 vld_p2;
  logic                 signErr_p2;
  logic                 bitClk_p2;
  logic [15:0]          errCount_p2;
  logic [CW-1:0]        halfCnt;
  logic                 b1;
  logic                 b2;
  logic                 kOdd;

  soqpsk_int_dump #(.DW(DW), .CW(CW), .AW(AW)) intDump (
    .clk        (clk),
    .reset      (reset),
    .sampleEn   (bus.sampleEn),
    .discIn     (bus.discIn),
    .symSync    (bus.symSync),
    .symDivider (bus.symDivider),
    .dump       (dump_p0),
    .dumpEn     (dumpEn_p0)
  );

  // Stage p0: slicer on the dump-cycle accumulator; exactly +/-threshold slices to 0.
  always_comb begin
    n_p0   = (DW+1)'(dump_p0 >>> bus.accShift);
    thr_p0 = {1'b0, bus.threshold};
    if (n_p0 > thr_p0)       tern_p0 = TERN_POS;
    else if (n_p0 < -thr_p0) tern_p0 = TERN_NEG;
    else                     tern_p0 = TERN_ZERO;
  end

  // Stage p1: registered ternary symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ternOut_p1 <= TERN_ZERO;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= dumpEn_p0;
      if (dumpEn_p0) ternOut_p1 <= tern_p0;
    end
  end

  // A nonzero symbol must carry sign (+/-)(a[k-1]*a[k]), '+' on odd symbol index.
  always_comb begin
    alphaNz  = (ternOut_p1 != TERN_ZERO);
    bitNew   = b2 ^ alphaNz;
    prod     = bitSign(b1) * bitSign(bitNew);
    expSign  = kOdd ? prod : -prod;
    viol     = alphaNz && ($signed(ternOut_p1) != expSign);
    halfLoad = CW'(({1'b0, bus.symDivider} + (CW+1)'(1)) >> 1);
  end

  // Stage p2: recovered bit, checker, error counter and bit clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitOut_p2   <= 1'b0;
      vld_p2      <= 1'b0;
      signErr_p2  <= 1'b0;
      bitClk_p2   <= 1'b0;
      errCount_p2 <= '0;
      halfCnt     <= '0;
      b1          <= 1'b0;
      b2          <= 1'b0;
      kOdd        <= 1'b0;
    end else begin
      vld_p2     <= 1'b0;
      signErr_p2 <= 1'b0;
      if (vld_p1) begin
        bitOut_p2  <= bitNew;
        vld_p2     <= 1'b1;
        signErr_p2 <= viol;
        if (viol) errCount_p2 <= satInc(errCount_p2);
        b2         <= b1;
        b1         <= bitNew;
        kOdd       <= ~kOdd;
        bitClk_p2  <= 1'b1;
        halfCnt    <= halfLoad;
      end else if (bitClk_p2) begin
        if (halfCnt == '0) begin
          bitClk_p2 <= 1'b0;
        end else if (bus.sampleEn) begin
          halfCnt <= halfCnt - CW'(1);
          if (halfCnt == CW'(1)) bitClk_p2 <= 1'b0;
        end
      end
      if (bus.symSync) kOdd <= 1'b0;
    end
  end

  assign bus.ternOut  = ternOut_p1;
  assign bus.bitOut   = bitOut_p2;
  assign bus.bitValid = vld_p2;
  assign bus.bitClk   = bitClk_p2;
  assign bus.signErr  = signErr_p2;
  assign bus.errCount = errCount_p2;

endmodule

// File: tb/tb_soqpsk_ternary_decoder.sv
// Directed bench for soqpsk_ternary_decoder with a bench-side SOQPSK precoder model.
module tb_soqpsk_ternary_decoder;

  localparam int DW = 18;
  localparam int CW = 16;

  logic clk;
  logic reset;
  int   cyc = 0;

  soqpsk_ternary_decoder_if #(.DW(DW), .CW(CW)) bus ();

  soqpsk_ternary_decoder #(.DW(DW), .CW(CW), .AW(DW+CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   nChecks = 0;
  int   nPass   = 0;
  int   bvCount = 0;
  int   bvCyc   = 0;
  int   errPulses = 0;
  logic bitQ [$];

  always @(negedge clk) begin
    if (bus.bitValid) begin
      bitQ.push_back(bus.bitOut);
      bvCyc = cyc;
      bvCount++;
    end
    if (bus.signErr) errPulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendN(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      bus.sampleEn = 1'b1;
      bus.discIn   = 18'(val);
      tick();
    end
    bus.sampleEn = 1'b0;
  endtask

  task automatic syncPulse(input logic withSample, input int val);
    bus.symSync  = 1'b1;
    bus.sampleEn = withSample;
    bus.discIn   = 18'(val);
    tick();
    bus.symSync  = 1'b0;
    bus.sampleEn = 1'b0;
  endtask

  // Modulator model: alpha[k] = (-1)^(k+1) * L(a[k-1]) * (a[k] - a[k-2]).
  logic mA1 = 1'b0;
  logic mA2 = 1'b0;
  logic mK  = 1'b0;

  task automatic modSym(input logic a, input logic inject, input int nSamp, input int amp);
    int diff, lvl, sgn, alpha;
    diff  = int'(a) - int'(mA2);
    lvl   = mA1 ? 1 : -1;
    sgn   = mK ? 1 : -1;
    alpha = sgn * lvl * diff;
    if (inject) alpha = -alpha;
    sendN(nSamp, alpha * amp);
    mA2 = mA1;
    mA1 = a;
    mK  = ~mK;
  endtask

  logic rtBits [21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  int   lastCyc;
  int   bv0;
  int   ep0;
  logic expBit;

  initial begin
    reset          = 1'b0;
    bus.sampleEn   = 1'b0;
    bus.discIn     = '0;
    bus.symSync    = 1'b0;
    bus.symDivider = 16'd3;
    bus.accShift   = 4'd0;
    bus.threshold  = 18'd500;
    idle(2);
    chk("reset_outputs", {bus.ternOut, bus.bitOut, bus.bitValid, bus.bitClk, bus.signErr, bus.errCount}, 0);
    reset = 1'b1;
    idle(1);

    // Constant +200 over 4 samples: dump 800 > 500.
    sendN(3, 200);
    lastCyc = cyc;
    sendN(1, 200);
    chk("const_tern_pos", bus.ternOut, 2'b01);
    idle(3);
    chk("const_latency", bvCyc - lastCyc, 2);
    chk("const_bit", bus.bitOut, 1'b1);

    // Dump exactly at threshold slices to zero.
    bus.threshold = 18'd800;
    sendN(4, 200);
    chk("thr_boundary_zero", bus.ternOut, 2'b00);
    idle(3);
    chk("thr_boundary_bit", bus.bitOut, 1'b0);

    // -800 below -799: -1, and no sign violation for this history.
    bus.threshold = 18'd799;
    sendN(4, -200);
    chk("neg_tern", bus.ternOut, 2'b11);
    idle(1);
    chk("bitclk_rise", bus.bitClk, 1'b1);
    chk("neg_bit", bus.bitOut, 1'b0);
    idle(3);
    chk("bitclk_hold_idle", bus.bitClk, 1'b1);
    sendN(1, 0);
    chk("bitclk_after_1strobe", bus.bitClk, 1'b1);
    sendN(1, 0);
    chk("bitclk_after_2strobe", bus.bitClk, 1'b0);
    chk("no_err_so_far", errPulses, 0);

    // symSync mid-symbol restarts the 8-sample window and discards its own sample.
    bus.symDivider = 16'd7;
    bus.threshold  = 18'd1000;
    syncPulse(1'b1, -30000);
    bv0 = bvCount;
    sendN(2, 300);
    syncPulse(1'b1, -30000);
    sendN(7, 300);
    idle(3);
    chk("sync_no_early_dump", bvCount, bv0);
    sendN(1, 300);
    idle(3);
    chk("sync_dump_count", bvCount, bv0 + 1);
    chk("sync_tern", bus.ternOut, 2'b01);
    chk("sync_bit", bus.bitOut, 1'b1);

    // symSync coincident with the dump sample suppresses the symbol.
    bv0 = bvCount;
    sendN(7, 300);
    syncPulse(1'b1, 300);
    idle(3);
    chk("sync_coincident_no_bv", bvCount, bv0);

    // Reset mid-symbol while bitClk is high.
    sendN(8, -300);
    idle(2);
    chk("pre_reset_bitclk", bus.bitClk, 1'b1);
    sendN(3, 300);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.ternOut, bus.bitOut, bus.bitValid, bus.bitClk, bus.signErr, bus.errCount}, 0);
    #3 reset = 1'b1;
    tick();
    bv0 = bvCount;
    sendN(7, 300);
    idle(3);
    chk("post_reset_no_early", bvCount, bv0);
    sendN(1, 300);
    idle(3);
    chk("post_reset_dump", bvCount, bv0 + 1);
    chk("post_reset_bit", bus.bitOut, 1'b1);

    // Precoder round trip from a clean state, exercising accShift on both signs.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    mA1 = 1'b0;
    mA2 = 1'b0;
    mK  = 1'b0;
    bitQ.delete();
    bus.accShift = 4'd2;
    for (int k = 0; k < 21; k++) modSym(rtBits[k], 1'b0, 8, 1200);
    idle(3);
    chk("rt_count", bitQ.size(), 21);
    for (int k = 0; k < 21; k++)
      if (k < bitQ.size()) chk($sformatf("rt_bit%0d", k), bitQ[k], rtBits[k]);
    chk("rt_errcount", bus.errCount, 0);

    // Single injected sign violation.
    ep0    = errPulses;
    expBit = mA2 ^ 1'b1;
    modSym(expBit, 1'b1, 8, 1200);
    idle(3);
    chk("viol_bit", bus.bitOut, expBit);
    chk("viol_pulses", errPulses, ep0 + 1);
    chk("viol_errcount", bus.errCount, 1);

    // 70000 back-to-back violations at one sample per symbol.
    bus.symDivider = 16'd0;
    bus.accShift   = 4'd0;
    syncPulse(1'b0, 0);
    mK = 1'b0;
    for (int k = 0; k < 70000; k++) modSym(mA2 ^ 1'b1, 1'b1, 1, 2000);
    idle(1);
    chk("div0_bitclk_high", bus.bitClk, 1'b1);
    idle(1);
    chk("div0_bitclk_low", bus.bitClk, 1'b0);
    idle(2);
    chk("sat_errcount", bus.errCount, 16'hFFFF);
    chk("sat_pulses", errPulses, 70001);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
